// File: rtl/exu_wb_arb.sv
// Writeback arbiter: merges the ALU writeback stream with buffered long-latency results onto one RF write port.
// Optional macro WB_BYPASS_EN: secondary results skip the FIFO when it is empty and the ALU is idle.
module exu_wb_arb #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic [4:0]      alu_wb_rd_addr,
    input  logic            alu_wb_rd_wr_en,
    input  logic [XLEN-1:0] alu_instr_tag,
    input  logic [31:0]     alu_instr,
    input  logic            sec_valid,
    output logic            sec_ready,
    input  logic [XLEN-1:0] sec_data,
    input  logic [4:0]      sec_rd_addr,
    input  logic [XLEN-1:0] sec_instr_tag,
    input  logic [31:0]     sec_instr,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            ret_valid,
    output logic [XLEN-1:0] ret_instr_tag,
    output logic [31:0]     ret_instr,
    output logic [31:0]     wb_pend_mask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

    logic [XLEN-1:0]       data_mem_r  [FIFO_DEPTH];
    logic [4:0]            rd_mem_r    [FIFO_DEPTH];
    logic [XLEN-1:0]       tag_mem_r   [FIFO_DEPTH];
    logic [31:0]           instr_mem_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  sec_fire_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  byp_s;
    logic                  sel_s;
    logic [4:0]            sel_rd_s;
    logic [XLEN-1:0]       sel_data_s;
    logic [XLEN-1:0]       sel_tag_s;
    logic [31:0]           sel_instr_s;
    logic [31:0]           mask_s;

    // ready comes from the registered count only, so a same-cycle pop never opens the door
    assign full_s     = (count_r == DEPTH_C);
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign sec_ready  = ~full_s & ~rst;
    assign sec_fire_s = sec_valid & sec_ready;
    assign push_s     = sec_fire_s & ~byp_s;

    // Fixed-priority source selection: ALU, then FIFO head, then (optionally) the bypass
    always_comb begin
        pop_s       = 1'b0;
        byp_s       = 1'b0;
        sel_s       = 1'b0;
        sel_rd_s    = 5'd0;
        sel_data_s  = {XLEN{1'b0}};
        sel_tag_s   = {XLEN{1'b0}};
        sel_instr_s = 32'd0;
        if (alu_wb_rd_wr_en) begin
            sel_s       = 1'b1;
            sel_rd_s    = alu_wb_rd_addr;
            sel_data_s  = alu_wb_data;
            sel_tag_s   = alu_instr_tag;
            sel_instr_s = alu_instr;
        end else if (!empty_s) begin
            pop_s       = 1'b1;
            sel_s       = 1'b1;
            sel_rd_s    = rd_mem_r[rd_ptr_r];
            sel_data_s  = data_mem_r[rd_ptr_r];
            sel_tag_s   = tag_mem_r[rd_ptr_r];
            sel_instr_s = instr_mem_r[rd_ptr_r];
        end
`ifdef WB_BYPASS_EN
        else if (sec_fire_s) begin
            byp_s       = 1'b1;
            sel_s       = 1'b1;
            sel_rd_s    = sec_rd_addr;
            sel_data_s  = sec_data;
            sel_tag_s   = sec_instr_tag;
            sel_instr_s = sec_instr;
        end
`endif
        else begin
            sel_s = 1'b0;
        end
    end

    // FIFO control: pointers, occupancy and per-entry valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {FIFO_DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO payload storage; contents are qualified by valid_r so they need no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r]  <= sec_data;
            rd_mem_r[wr_ptr_r]    <= sec_rd_addr;
            tag_mem_r[wr_ptr_r]   <= sec_instr_tag;
            instr_mem_r[wr_ptr_r] <= sec_instr;
        end
    end

    // Writeback/retire output register; x0 targets retire without writing the RF
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= 5'd0;
            rf_wr_data    <= {XLEN{1'b0}};
            ret_valid     <= 1'b0;
            ret_instr_tag <= {XLEN{1'b0}};
            ret_instr     <= 32'd0;
        end else begin
            ret_valid <= sel_s;
            rf_wr_en  <= sel_s & (sel_rd_s != 5'd0);
            if (sel_s) begin
                rf_wr_addr    <= sel_rd_s;
                rf_wr_data    <= sel_data_s;
                ret_instr_tag <= sel_tag_s;
                ret_instr     <= sel_instr_s;
            end
        end
    end

    // Pending-destination mask built from the registered valid flags
    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_r[i]) begin
                mask_s = mask_s | rd_onehot(rd_mem_r[i]);
            end else begin
                mask_s = mask_s;
            end
        end
        mask_s = mask_s & ~32'd1;
    end

    assign wb_pend_mask = mask_s;

endmodule
